// File: rtl/ram_bus_master_if.sv
// ram_bus_master_if
//   Request/response channel between the CPU control unit and the RAM bus
//   master. The core is the master of this channel; ram_bus_master is the
//   slave.
//   Signals:
//     req_valid  core -> master   request present
//     req_ready  master -> core   high only while the bus master is idle
//     req_we     core -> master   1 = write, 0 = read
//     req_addr   core -> master   target address (ADDR_W)
//     req_wdata  core -> master   write data (DATA_W)
//     rsp_valid  master -> core   one-cycle completion pulse
//     rsp_rdata  master -> core   read data, held until the next read completes
//     rsp_err    master -> core   read-back mismatch flag
interface ram_bus_master_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ram_bus_master.sv
// ram_bus_master
//   Bus initiator for the 4-bit asynchronous RAM. Accepts one read or write at
//   a time from the core, sequences SETUP / ACCESS (strobe) / HOLD on the RAM
//   pins, owns the tristate driver of the shared data bus, and returns a
//   one-cycle completion pulse with read data.
//   Ports:
//     clk       rising-edge clock
//     reset     asynchronous, active-low reset
//     bus       request/response channel (ram_bus_master_if.slave)
//     mem_addr  RAM address (registered)
//     mem_cs    RAM chip select (registered)
//     mem_we    RAM write enable (registered)
//     mem_data  bidirectional RAM data bus
//   Build option: RAM_BUS_MASTER_READBACK_EN adds a read-back sequence after
//   every write and reports a mismatch on rsp_err; without it rsp_err is 0.
module ram_bus_master #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 4,
  parameter int SETUP_CYC  = 1,
  parameter int ACCESS_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  ram_bus_master_if.slave   bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_cs,
  output logic              mem_we,
  inout  wire  [DATA_W-1:0] mem_data
);

  localparam int MAX_CYC = (SETUP_CYC > ACCESS_CYC) ? SETUP_CYC : ACCESS_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SETUP     = 3'd1;
  localparam logic [2:0] S_ACCESS    = 3'd2;
  localparam logic [2:0] S_HOLD      = 3'd3;
`ifdef RAM_BUS_MASTER_READBACK_EN
  localparam logic [2:0] S_RB_SETUP  = 3'd4;
  localparam logic [2:0] S_RB_ACCESS = 3'd5;
  localparam logic [2:0] S_RB_HOLD   = 3'd6;
`endif

  logic [2:0]        state, nxt;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              drive_q;
  logic              rsp_valid_q;
  logic              accept;
  logic              setup_done;
  logic              access_done;
  logic              sample_rd;
  logic              cs_nxt;
  logic              rsp_nxt;

  assign accept      = (state == S_IDLE) && bus.req_valid;
  assign setup_done  = (cnt == CNT_W'(SETUP_CYC - 1));
  assign access_done = (cnt == CNT_W'(ACCESS_CYC - 1));

  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;

  // Only a write ever drives the bus, so the master can never fight the RAM
  // while it is being read.
  assign mem_data = drive_q ? wdata_q : {DATA_W{1'bz}};

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:      if (bus.req_valid) nxt = S_SETUP;
      S_SETUP:     if (setup_done)    nxt = S_ACCESS;
      S_ACCESS:    if (access_done)   nxt = S_HOLD;
`ifdef RAM_BUS_MASTER_READBACK_EN
      S_HOLD:      nxt = we_q ? S_RB_SETUP : S_IDLE;
      S_RB_SETUP:  if (setup_done)    nxt = S_RB_ACCESS;
      S_RB_ACCESS: if (access_done)   nxt = S_RB_HOLD;
      S_RB_HOLD:   nxt = S_IDLE;
`else
      S_HOLD:      nxt = S_IDLE;
`endif
      default:     nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so the RAM pins change
  // exactly on phase boundaries with no combinational path from req_*.
  always_comb begin
`ifdef RAM_BUS_MASTER_READBACK_EN
    cs_nxt    = (nxt == S_ACCESS) || (nxt == S_RB_ACCESS);
    rsp_nxt   = ((nxt == S_HOLD) && !we_q) || (nxt == S_RB_HOLD);
    sample_rd = access_done &&
                (((state == S_ACCESS) && !we_q) || (state == S_RB_ACCESS));
`else
    cs_nxt    = (nxt == S_ACCESS);
    rsp_nxt   = (nxt == S_HOLD);
    sample_rd = access_done && (state == S_ACCESS) && !we_q;
`endif
  end

  // ---- FSM / request capture / RAM pin registers ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      drive_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      mem_addr    <= '0;
      mem_cs      <= 1'b0;
      mem_we      <= 1'b0;
    end else begin
      state <= nxt;
      // Phase counter restarts on every phase entry.
      cnt   <= (nxt != state) ? '0 : cnt + 1'b1;
      if (accept) begin
        we_q     <= bus.req_we;
        wdata_q  <= bus.req_wdata;
        mem_addr <= bus.req_addr;
      end
      mem_cs      <= cs_nxt;
      mem_we      <= (nxt == S_ACCESS) && we_q;
      // Drive window is SETUP..HOLD of a write; read-back phases stay Z.
      drive_q     <= accept ? bus.req_we
                            : (we_q && ((nxt == S_SETUP) || (nxt == S_ACCESS) ||
                                        (nxt == S_HOLD)));
      rsp_valid_q <= rsp_nxt;
      if (sample_rd) rdata_q <= mem_data;
    end
  end

`ifdef RAM_BUS_MASTER_READBACK_EN
  logic err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (sample_rd) begin
      err_q <= (state == S_RB_ACCESS) && (mem_data != wdata_q);
    end
  end

  assign bus.rsp_err = err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_bus_master.sv
// tb_ram_bus_master
//   Self-checking bench for ram_bus_master with a behavioural asynchronous RAM
//   (optional bit0 stuck-at-0 on reads) and a transaction-level reference
//   model. Honors RAM_BUS_MASTER_READBACK_EN when the design is built with it.
module tb_ram_bus_master;

  localparam int SC   = 1;
  localparam int AC   = 2;
  localparam int LAT  = SC + AC + 1;
`ifdef RAM_BUS_MASTER_READBACK_EN
  localparam bit RB   = 1'b1;
`else
  localparam bit RB   = 1'b0;
`endif
  localparam int WLAT = RB ? 2 * LAT : LAT;

  logic        clk;
  logic        reset;
  logic [11:0] mem_addr;
  logic        mem_cs;
  logic        mem_we;
  wire  [3:0]  mem_data;

  ram_bus_master_if #(.ADDR_W(12), .DATA_W(4)) bus ();

  ram_bus_master #(
    .ADDR_W(12), .DATA_W(4), .SETUP_CYC(SC), .ACCESS_CYC(AC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .mem_addr (mem_addr),
    .mem_cs   (mem_cs),
    .mem_we   (mem_we),
    .mem_data (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: drives the bus while selected for read, stores on
  // every clock where cs & we are both high.
  logic [3:0] ram [0:4095];
  logic       ram_inited = 1'b0;
  logic       stuck;
  logic [3:0] ram_q;

  function automatic logic [3:0] init_val(input int i);
    logic [11:0] a;
    a = i[11:0];
    return a[3:0] ^ a[7:4] ^ a[11:8];
  endfunction

  always @(posedge clk) begin
    if (!ram_inited) begin
      for (int i = 0; i < 4096; i++) ram[i] <= init_val(i);
      ram_inited <= 1'b1;
    end else if (mem_cs && mem_we) begin
      ram[mem_addr] <= mem_data;
    end
  end

  always_comb ram_q = stuck ? (ram[mem_addr] & 4'hE) : ram[mem_addr];
  assign mem_data = (mem_cs && !mem_we) ? ram_q : 4'bzzzz;

  // Reference model state
  logic [3:0] model_mem [0:4095];
  logic [3:0] exp_rdata;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One complete transfer, observed cycle by cycle from acceptance to rsp_valid.
  task automatic xfer(input logic we, input logic [11:0] addr, input logic [3:0] wd);
    int lat = 0, cs_n = 0, we_n = 0, bad_addr = 0, bad_data = 0, bad_rdy = 0, bad_we = 0;
    logic [3:0] view;
    logic       exp_err;
    @(negedge clk);
    check("ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wd;
    @(posedge clk);
    for (int c = 1; c <= 24 && lat == 0; c++) begin
      @(negedge clk);
      // Request inputs scrambled while busy; the captured copy must be used.
      bus.req_valid = 1'b0;
      bus.req_we    = 1'($urandom_range(0, 1));
      bus.req_addr  = 12'($urandom_range(0, 4095));
      bus.req_wdata = 4'($urandom_range(0, 15));
      if (mem_addr != addr) bad_addr++;
      if (mem_cs) cs_n++;
      if (mem_we) begin we_n++; if (!mem_cs) bad_we++; end
      if (we && c <= LAT && mem_data != wd) bad_data++;
      if (bus.req_ready) bad_rdy++;
      if (bus.rsp_valid) lat = c;
    end
    if (we) model_mem[addr] = wd;
    view = stuck ? (model_mem[addr] & 4'hE) : model_mem[addr];
    if (!we || RB) exp_rdata = view;
    exp_err = RB && we && (view != wd);
    check("latency",   lat,  we ? WLAT : LAT);
    check("cs_cycles", cs_n, (we && RB) ? 2 * AC : AC);
    check("we_cycles", we_n, we ? AC : 0);
    check("addr_hold", bad_addr, 0);
    check("we_no_cs",  bad_we,   0);
    check("wdata_bus", bad_data, 0);
    check("ready_busy", bad_rdy, 0);
    check("rdata",     bus.rsp_rdata, exp_rdata);
    check("err",       bus.rsp_err,   exp_err);
    @(negedge clk);
    check("rsp_pulse", bus.rsp_valid, 0);
    check("ready_back", bus.req_ready, 1);
  endtask

  initial begin
    int lat1, rdy, lat2, bad;
    logic        rw;
    logic [11:0] ra;
    logic [3:0]  rd;

    for (int i = 0; i < 4096; i++) model_mem[i] = init_val(i);
    exp_rdata = 4'h0;
    stuck = 1'b0;
    reset = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 12'h123; bus.req_wdata = 4'hA;

    // Reset held with a pending request
    repeat (3) @(negedge clk);
    check("rst_cs",    mem_cs, 0);
    check("rst_we",    mem_we, 0);
    check("rst_addr",  mem_addr, 0);
    check("rst_rsp",   bus.rsp_valid, 0);
    check("rst_rdata", bus.rsp_rdata, 0);
    check("rst_err",   bus.rsp_err, 0);
    reset = 1'b1;
    bus.req_valid = 1'b0;
    #1;
    check("rst_ready", bus.req_ready, 1);

    // Directed write/read
    xfer(1'b1, 12'h123, 4'hA);
    xfer(1'b0, 12'h123, 4'h0);
    xfer(1'b1, 12'h000, 4'h9);

    // Back-to-back with req_valid held high: write 0xFFF then read 0x000
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 12'hFFF; bus.req_wdata = 4'h5;
    @(posedge clk);
    lat1 = 0; rdy = 0;
    for (int c = 1; c <= 40 && rdy == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin bus.req_we = 1'b0; bus.req_addr = 12'h000; end
      if (bus.rsp_valid) lat1 = c;
      if (bus.req_ready) rdy = c;
    end
    check("b2b_wlat", lat1, WLAT);
    check("b2b_ready", rdy, WLAT + 1);
    model_mem[12'hFFF] = 4'h5;
    @(posedge clk);
    lat2 = 0;
    for (int c = 1; c <= 24 && lat2 == 0; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.rsp_valid) lat2 = c;
    end
    exp_rdata = model_mem[12'h000];
    check("b2b_rlat", lat2, LAT);
    check("b2b_rdata", bus.rsp_rdata, exp_rdata);
    check("b2b_err", bus.rsp_err, 0);
    xfer(1'b0, 12'hFFF, 4'h0);

    // Reset in the second strobe cycle of a write
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 12'h456; bus.req_wdata = 4'h3;
    @(posedge clk);
    @(negedge clk); bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_pre_cs", mem_cs, 1);
    reset = 1'b0;
    #1;
    check("abort_cs", mem_cs, 0);
    check("abort_we", mem_we, 0);
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rsp_valid) bad++;
    end
    check("abort_no_rsp", bad, 0);
    exp_rdata = 4'h0;
    check("abort_rdata", bus.rsp_rdata, 0);
    xfer(1'b0, 12'h789, 4'h0);
    xfer(1'b1, 12'h456, 4'h3);
    xfer(1'b0, 12'h456, 4'h0);

    // Randomized traffic
    for (int n = 0; n < 30; n++) begin
      rw = 1'($urandom_range(0, 1));
      ra = 12'($urandom_range(0, 4095));
      rd = 4'($urandom_range(0, 15));
      xfer(rw, ra, rd);
    end

    // Read-back with a stuck-at-0 bit0, then fault-free
    stuck = 1'b1;
    xfer(1'b1, 12'h7FF, 4'hF);
    stuck = 1'b0;
    xfer(1'b1, 12'h7FF, 4'hF);
    xfer(1'b0, 12'h7FF, 4'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
